// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one uart_tx between NUM_REQ byte requesters.
// Latency: accept in IDLE at cycle N, uart_start from N+1, frame_done one cycle after busy is seen low.
// Backpressure: req_ready is only given in IDLE with uart_busy low; optional UART_ARB_LOCK_EN adds req_lock.
module uart_tx_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDW     = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [8*NUM_REQ-1:0]   req_data,
`ifdef UART_ARB_LOCK_EN
    input  logic [NUM_REQ-1:0]     req_lock,
`endif
    output logic [NUM_REQ-1:0]     req_ready,
    output logic                   uart_start,
    output logic [7:0]             uart_data,
    input  logic                   uart_busy,
    output logic [IDW-1:0]         grant_id,
    output logic                   arb_active,
    output logic                   frame_done
);

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_START     = 2'd1;
    localparam logic [1:0] S_WAIT_DONE = 2'd2;
    localparam logic [1:0] S_DONE      = 2'd3;

    logic [1:0]     state_q, state_d;
    logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0] grant_id_q, grant_id_d;
    logic [7:0]     uart_data_q, uart_data_d;

    logic           win_found;
    logic [IDW-1:0] win_idx;
    logic [IDW-1:0] cand;
    logic           lock_hit;
    logic [7:0]     win_data;
    logic           grant_now;

    // (base + off) modulo NUM_REQ, for off < NUM_REQ.
    function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NUM_REQ) begin
            s = s - NUM_REQ;
        end
        return s[IDW-1:0];
    endfunction

    // Pick the winner: lowest offset from rr_ptr wins; a locked previous owner overrides.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        lock_hit  = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = wrap_add(rr_ptr_q, k);
            if (req_valid[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
`ifdef UART_ARB_LOCK_EN
        if (req_lock[grant_id_q] && req_valid[grant_id_q]) begin
            win_found = 1'b1;
            win_idx   = grant_id_q;
            lock_hit  = 1'b1;
        end
`endif
    end

    // Mux out the winner's byte.
    always_comb begin
        win_data = 8'h00;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_idx == IDW'(i)) begin
                win_data = req_data[8*i +: 8];
            end
        end
    end

    // Handshake: only in IDLE, only when the transmitter is free, never while in reset.
    always_comb begin
        grant_now = (state_q == S_IDLE) && win_found && !uart_busy && !rst;
        req_ready = grant_now ? (NUM_REQ'(1) << win_idx) : '0;
    end

    // Frame sequencing: launch, wait for busy to fall, report completion.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        grant_id_d  = grant_id_q;
        uart_data_d = uart_data_q;
        case (state_q)
            S_IDLE: begin
                if (grant_now) begin
                    uart_data_d = win_data;
                    grant_id_d  = win_idx;
                    rr_ptr_d    = lock_hit ? rr_ptr_q : wrap_add(win_idx, 1);
                    state_d     = S_START;
                end
            end
            S_START: begin
                // uart_tx ignores start once busy, so one overlapping cycle is harmless.
                if (uart_busy) begin
                    state_d = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                // Busy falling marks completion; tx_done is sticky and unusable here.
                if (!uart_busy) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers with synchronous reset; reset abandons any frame in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            rr_ptr_q    <= '0;
            grant_id_q  <= '0;
            uart_data_q <= 8'h00;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_id_q  <= grant_id_d;
            uart_data_q <= uart_data_d;
        end
    end

    assign uart_start = (state_q == S_START);
    assign uart_data  = uart_data_q;
    assign grant_id   = grant_id_q;
    assign arb_active = (state_q != S_IDLE);
    assign frame_done = (state_q == S_DONE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a behavioural uart_tx and a cycle model.
// Latency: checks every cycle at the falling edge against the model.
// Backpressure: uart busy comes from the bench transmitter plus an external override.
module tb_uart_tx_arbiter;
    localparam int NUM_REQ = 4;
    localparam int IDW     = 2;
    localparam int FRAME   = 5;

    localparam int P_IDLE   = 0;
    localparam int P_LAUNCH = 1;
    localparam int P_SEND   = 2;
    localparam int P_FINISH = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req_valid = '0;
    logic [31:0] req_data  = '0;
`ifdef UART_ARB_LOCK_EN
    logic [3:0]  req_lock  = '0;
`endif
    logic [3:0]  req_ready;
    logic        uart_start;
    logic [7:0]  uart_data;
    logic        uart_busy;
    logic [1:0]  grant_id;
    logic        arb_active;
    logic        frame_done;

    logic tx_busy    = 1'b0;
    logic force_busy = 1'b0;
    assign uart_busy = tx_busy | force_busy;

    uart_tx_arbiter #(.NUM_REQ(NUM_REQ), .IDW(IDW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_data   (req_data),
`ifdef UART_ARB_LOCK_EN
        .req_lock   (req_lock),
`endif
        .req_ready  (req_ready),
        .uart_start (uart_start),
        .uart_data  (uart_data),
        .uart_busy  (uart_busy),
        .grant_id   (grant_id),
        .arb_active (arb_active),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Behavioural uart_tx: takes start when idle, stays busy FRAME cycles, logs the byte.
    logic [7:0] cap_d[$];
    int         cap_g[$];
    initial begin
        logic s;
        logic [7:0] d;
        int g;
        int cnt;
        cnt = 0;
        forever begin
            @(negedge clk);
            s = uart_start;
            d = uart_data;
            g = int'(grant_id);
            @(posedge clk);
            #2;
            if (tx_busy) begin
                cnt--;
                if (cnt == 0) tx_busy = 1'b0;
            end else if (s) begin
                tx_busy = 1'b1;
                cnt = FRAME;
                cap_d.push_back(d);
                cap_g.push_back(g);
            end
        end
    end

    // Event monitor: accepted requesters, completions, start edges, grants under busy.
    int acc_q[$];
    int acc_cyc = 0;
    int start_cyc = 0;
    int start_cnt = 0;
    int fd_cnt = 0;
    int acc_while_busy = 0;
    initial begin
        logic prev_start;
        prev_start = 1'b0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_ready[i]) begin
                    acc_q.push_back(i);
                    acc_cyc = cyc;
                    if (uart_busy) acc_while_busy++;
                end
            end
            if (frame_done) fd_cnt++;
            if (uart_start && !prev_start) begin
                start_cyc = cyc;
                start_cnt++;
            end
            prev_start = uart_start;
        end
    end

    // Cycle model: a frame owner, a phase and a round-robin pointer, checked every falling edge.
    int         m_on = 0;
    int         m_ph = P_IDLE;
    int         m_rr = 0;
    int         m_gid = 0;
    logic [7:0] m_data = 8'h00;

    initial begin
        forever begin
            @(negedge clk);
            begin
                logic [3:0] exp_rdy;
                int win;
                bit hold;
                exp_rdy = '0;
                win = -1;
                hold = 1'b0;
                if (m_on != 0 && !rst && m_ph == P_IDLE && !uart_busy && req_valid != 0) begin
`ifdef UART_ARB_LOCK_EN
                    if (req_lock[m_gid] && req_valid[m_gid]) begin
                        win = m_gid;
                        hold = 1'b1;
                    end
`endif
                    for (int k = 0; k < NUM_REQ; k++) begin
                        if (win < 0 && req_valid[(m_rr + k) % NUM_REQ]) win = (m_rr + k) % NUM_REQ;
                    end
                    exp_rdy[win] = 1'b1;
                end
                if (m_on != 0) begin
                    chk("req_ready", 32'(req_ready), 32'(exp_rdy));
                    chk("uart_start", 32'(uart_start), 32'(m_ph == P_LAUNCH));
                    chk("uart_data", 32'(uart_data), 32'(m_data));
                    chk("grant_id", 32'(grant_id), 32'(m_gid));
                    chk("arb_active", 32'(arb_active), 32'(m_ph != P_IDLE));
                    chk("frame_done", 32'(frame_done), 32'(m_ph == P_FINISH));
                end
                if (rst) begin
                    m_on = 1; m_ph = P_IDLE; m_rr = 0; m_gid = 0; m_data = 8'h00;
                end else if (m_on != 0) begin
                    case (m_ph)
                        P_IDLE: if (win >= 0) begin
                            m_data = req_data[8*win +: 8];
                            m_gid = win;
                            if (!hold) m_rr = (win + 1) % NUM_REQ;
                            m_ph = P_LAUNCH;
                        end
                        P_LAUNCH: if (uart_busy) m_ph = P_SEND;
                        P_SEND:   if (!uart_busy) m_ph = P_FINISH;
                        default:  m_ph = P_IDLE;
                    endcase
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic run_accepts(input int n, input int budget, input logic [3:0] clear_mask);
        int t;
        t = 0;
        while (acc_q.size() < n && t < budget) begin
            step();
            t++;
        end
        if (acc_q.size() < n) chk("accept_timeout", 32'(acc_q.size()), 32'(n));
        req_valid = req_valid & ~clear_mask;
    endtask

    task automatic wait_idle(input int budget);
        int t;
        t = 0;
        while ((arb_active || uart_busy) && t < budget) begin
            step();
            t++;
        end
        if (arb_active || uart_busy) chk("idle_timeout", 32'(arb_active), 32'(0));
        step();
    endtask

    task automatic clear_logs();
        acc_q.delete();
        cap_d.delete();
        cap_g.delete();
        fd_cnt = 0;
        start_cnt = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values, checked while reset is held.
        rst = 1'b1;
        step(); step();
        chk("rst_uart_start", 32'(uart_start), 32'h0);
        chk("rst_uart_data", 32'(uart_data), 32'h0);
        chk("rst_grant_id", 32'(grant_id), 32'h0);
        chk("rst_frame_done", 32'(frame_done), 32'h0);
        chk("rst_arb_active", 32'(arb_active), 32'h0);
        chk("rst_req_ready", 32'(req_ready), 32'h0);
        rst = 1'b0;
        step();

        // Single requester.
        clear_logs();
        req_data[7:0] = 8'hA5;
        req_valid = 4'b0001;
        run_accepts(1, 20, 4'b0001);
        wait_idle(40);
        chk("t1_accepts", 32'(acc_q.size()), 32'd1);
        chk("t1_winner", 32'(acc_q[0]), 32'd0);
        chk("t1_line_byte", 32'(cap_d[0]), 32'hA5);
        chk("t1_frame_done_cnt", 32'(fd_cnt), 32'd1);
        chk("t1_start_latency", 32'(start_cyc - acc_cyc), 32'd1);
        chk("t1_grant_id", 32'(grant_id), 32'd0);

        // All four continuously valid: strict rotation.
        do_reset();
        clear_logs();
        req_data = 32'h43322110;
        req_valid = 4'b1111;
        run_accepts(5, 200, 4'b1111);
        wait_idle(40);
        chk("t2_frames", 32'(cap_d.size()), 32'd5);
        chk("t2_order0", 32'(acc_q[0]), 32'd0);
        chk("t2_order1", 32'(acc_q[1]), 32'd1);
        chk("t2_order2", 32'(acc_q[2]), 32'd2);
        chk("t2_order3", 32'(acc_q[3]), 32'd3);
        chk("t2_order4", 32'(acc_q[4]), 32'd0);
        chk("t2_byte1", 32'(cap_d[1]), 32'h21);
        chk("t2_byte3", 32'(cap_d[3]), 32'h43);
        chk("t2_byte4", 32'(cap_d[4]), 32'h10);
        chk("t2_frame_done_cnt", 32'(fd_cnt), 32'd5);

        // Transmitter busy from outside: nothing may launch until it drops.
        clear_logs();
        force_busy = 1'b1;
        req_data[15:8] = 8'h5A;
        req_valid = 4'b0010;
        repeat (8) step();
        chk("t3_no_ready", 32'(acc_q.size()), 32'd0);
        chk("t3_no_start", 32'(start_cnt), 32'd0);
        force_busy = 1'b0;
        run_accepts(1, 10, 4'b0010);
        wait_idle(40);
        chk("t3_winner", 32'(acc_q[0]), 32'd1);
        chk("t3_line_byte", 32'(cap_d[0]), 32'h5A);

        // Reset while the frame is on the line.
        clear_logs();
        req_data[23:16] = 8'h77;
        req_valid = 4'b0100;
        run_accepts(1, 20, 4'b0100);
        begin
            int t;
            t = 0;
            while (!tx_busy && t < 10) begin step(); t++; end
            if (!tx_busy) chk("t4_busy_timeout", 32'(tx_busy), 32'd1);
        end
        step();
        rst = 1'b1;
        req_data[7:0] = 8'h3C;
        req_valid = 4'b0001;
        step();
        rst = 1'b0;
        chk("t4_rst_arb_active", 32'(arb_active), 32'd0);
        chk("t4_rst_grant_id", 32'(grant_id), 32'd0);
        chk("t4_rst_uart_data", 32'(uart_data), 32'h00);
        chk("t4_busy_still_high", 32'(uart_busy), 32'd1);
        run_accepts(2, 30, 4'b0001);
        wait_idle(40);
        chk("t4_regrant", 32'(acc_q[1]), 32'd0);
        chk("t4_bytes", 32'({cap_d[0], cap_d[1]}), 32'h773C);

        // Requester 2 withdraws just before its turn; 3 wins and the pointer wraps to 0.
        clear_logs();
        req_data = 32'h33221100;
        req_valid = 4'b0010;
        run_accepts(1, 20, 4'b0010);
        req_valid = 4'b1100;
        begin
            int t;
            t = 0;
            while (!frame_done && t < 40) begin step(); t++; end
            if (!frame_done) chk("t5_done_timeout", 32'(frame_done), 32'd1);
        end
        req_valid = 4'b1000;
        run_accepts(2, 20, 4'b1000);
        chk("t5_skip_to_3", 32'(acc_q[1]), 32'd3);
        wait_idle(40);
        req_valid = 4'b0111;
        run_accepts(3, 20, 4'b1111);
        wait_idle(40);
        chk("t5_wrap_to_0", 32'(acc_q[2]), 32'd0);
        chk("t5_byte_3", 32'(cap_d[1]), 32'h33);

`ifdef UART_ARB_LOCK_EN
        // Locked requester 1 keeps the transmitter for three bytes, then 0 gets its turn.
        do_reset();
        clear_logs();
        req_valid = 4'b0001;
        run_accepts(1, 20, 4'b0001);
        wait_idle(40);
        clear_logs();
        req_lock = 4'b0010;
        req_valid = 4'b0011;
        begin
            int t;
            int c1;
            t = 0;
            while (acc_q.size() < 4 && t < 300) begin
                step();
                t++;
                c1 = 0;
                foreach (acc_q[j]) if (acc_q[j] == 1) c1++;
                if (c1 >= 3) req_valid[1] = 1'b0;
            end
            if (acc_q.size() < 4) chk("t6_timeout", 32'(acc_q.size()), 32'd4);
        end
        req_valid = 4'b0000;
        req_lock = 4'b0000;
        wait_idle(40);
        chk("t6_seq0", 32'(acc_q[0]), 32'd1);
        chk("t6_seq1", 32'(acc_q[1]), 32'd1);
        chk("t6_seq2", 32'(acc_q[2]), 32'd1);
        chk("t6_seq3", 32'(acc_q[3]), 32'd0);
`endif

        chk("grant_under_busy", 32'(acc_while_busy), 32'd0);
        repeat (2) step();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
